// File: rtl/rdx_wb_ctrl_pkg.sv
// Shared types and constants for the mixed-radix FFT write-back stage.
// Lane k of every vector is written to bank k.
package rdx_wb_ctrl_pkg;

    localparam int W_DATA   = 18;
    localparam int W_ADDR   = 10;
    localparam int FF_DEPTH = 32;
    localparam int W_CNT    = 12;
    localparam int N_LANES  = 5;
    localparam int W_PTR    = $clog2(FF_DEPTH);
    localparam int W_FCNT   = W_PTR + 1;

    localparam logic [2:0] RDX2 = 3'd2;
    localparam logic [2:0] RDX3 = 3'd3;
    localparam logic [2:0] RDX4 = 3'd4;
    localparam logic [2:0] RDX5 = 3'd5;

    typedef logic signed [W_DATA-1:0] sample_t;
    typedef sample_t [0:N_LANES-1]    lane_vec_t;
    typedef logic [W_ADDR-1:0]        addr_t;
    typedef addr_t [0:N_LANES-1]      addr_vec_t;

    // Bit k set when lane k is active for the given radix; unknown radix writes nothing.
    function automatic logic [N_LANES-1:0] lane_mask(input logic [2:0] factor);
        case (factor)
            RDX2:    lane_mask = 5'b00011;
            RDX3:    lane_mask = 5'b00111;
            RDX4:    lane_mask = 5'b01111;
            RDX5:    lane_mask = 5'b11111;
            default: lane_mask = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/rdx_wb_ctrl_if.sv
// Bus between the twiddle stage / read-side controller (master) and the
// write-back controller (slave).
interface rdx_wb_ctrl_if;
    import rdx_wb_ctrl_pkg::*;

    logic [2:0]       factor;
    addr_t            stride;
    logic [W_CNT-1:0] frame_len;
    logic             addr_wrreq;
    addr_t            addr_in;
    logic             sclr_ff_addr;
    logic             rdreq_ff_addr;
    logic             in_val;
    lane_vec_t        din_real;
    lane_vec_t        din_imag;
    logic [4:0]       wr_en;
    addr_vec_t        wr_addr;
    lane_vec_t        wr_real;
    lane_vec_t        wr_imag;
    logic             frame_done;
    logic             ff_full;
    logic             ff_empty;
    logic             err_ovf;
    logic             err_udf;

    modport master (
        output factor, stride, frame_len, addr_wrreq, addr_in, sclr_ff_addr,
               rdreq_ff_addr, in_val, din_real, din_imag,
        input  wr_en, wr_addr, wr_real, wr_imag, frame_done, ff_full, ff_empty,
               err_ovf, err_udf
    );

    modport slave (
        input  factor, stride, frame_len, addr_wrreq, addr_in, sclr_ff_addr,
               rdreq_ff_addr, in_val, din_real, din_imag,
        output wr_en, wr_addr, wr_real, wr_imag, frame_done, ff_full, ff_empty,
               err_ovf, err_udf
    );

endinterface

// File: rtl/rdx_addr_fifo.sv
// Synchronous base-address FIFO with registered read data, count-derived
// full/empty flags and a synchronous clear that overrides push and pop.
module rdx_addr_fifo
    import rdx_wb_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  sclr,
    input  logic  wrreq,
    input  addr_t din,
    input  logic  rdreq,
    output addr_t q,
    output logic  q_val,
    output logic  full,
    output logic  empty,
    output logic  ovf,
    output logic  udf
);

    addr_t             mem_r [FF_DEPTH];
    logic [W_PTR-1:0]  wr_ptr_r;
    logic [W_PTR-1:0]  rd_ptr_r;
    logic [W_FCNT-1:0] count_r;
    logic [W_FCNT-1:0] count_nxt_s;
    addr_t             q_r;
    logic              q_val_r;
    logic              full_r;
    logic              empty_r;
    logic              do_pop_s;
    logic              do_push_s;

    // A pop frees a slot, so push+pop on a full FIFO goes through.
    always_comb begin
        do_pop_s    = rdreq & ~empty_r & ~sclr;
        do_push_s   = wrreq & (~full_r | do_pop_s) & ~sclr;
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + W_FCNT'(1);
            2'b01:   count_nxt_s = count_r - W_FCNT'(1);
            default: count_nxt_s = count_r;
        endcase
        ovf = wrreq & full_r & ~do_pop_s & ~sclr;
        udf = rdreq & empty_r & ~sclr;
    end

    // Storage array: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy flags and registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            q_r      <= '0;
            q_val_r  <= 1'b0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else if (sclr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            q_val_r  <= 1'b0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + W_PTR'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + W_PTR'(1);
                q_r      <= mem_r[rd_ptr_r];
            end
            q_val_r <= do_pop_s;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == W_FCNT'(FF_DEPTH));
            empty_r <= (count_nxt_s == W_FCNT'(0));
        end
    end

    assign q     = q_r;
    assign q_val = q_val_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/rdx_wb_ctrl.sv
// FFT write-back stage: pairs each twiddled vector with its FIFO base address,
// issues per-bank writes two cycles after in_val and counts vectors per stage.
module rdx_wb_ctrl
    import rdx_wb_ctrl_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    rdx_wb_ctrl_if.slave bus
);

    addr_t              q_s;
    logic               q_val_s;
    logic               ovf_s;
    logic               udf_s;
    logic               vec_ok_s;
    logic               last_s;
    logic               drop_s;
    logic [N_LANES-1:0] mask_s;
    addr_vec_t          lane_addr_s;
    addr_t              stride_x2_s;
    addr_t              stride_x4_s;

    logic               v1_r;
    lane_vec_t          d1_real_r;
    lane_vec_t          d1_imag_r;
    logic [W_CNT-1:0]   cnt_r;
    logic [N_LANES-1:0] wr_en_r;
    addr_vec_t          wr_addr_r;
    lane_vec_t          wr_real_r;
    lane_vec_t          wr_imag_r;
    logic               frame_done_r;
    logic               err_ovf_r;
    logic               err_udf_r;

    rdx_addr_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (bus.sclr_ff_addr),
        .wrreq (bus.addr_wrreq),
        .din   (bus.addr_in),
        .rdreq (bus.rdreq_ff_addr),
        .q     (q_s),
        .q_val (q_val_s),
        .full  (bus.ff_full),
        .empty (bus.ff_empty),
        .ovf   (ovf_s),
        .udf   (udf_s)
    );

    // Lane addresses q + k*stride built from shifts; additions wrap at 2^W_ADDR.
    always_comb begin
        stride_x2_s    = bus.stride << 1;
        stride_x4_s    = bus.stride << 2;
        lane_addr_s[0] = q_s;
        lane_addr_s[1] = q_s + bus.stride;
        lane_addr_s[2] = q_s + stride_x2_s;
        lane_addr_s[3] = q_s + stride_x2_s + bus.stride;
        lane_addr_s[4] = q_s + stride_x4_s;
        vec_ok_s       = v1_r & q_val_s;
        mask_s         = lane_mask(bus.factor) & {N_LANES{vec_ok_s}};
        last_s         = (bus.frame_len != {W_CNT{1'b0}}) &&
                         (cnt_r == bus.frame_len - W_CNT'(1));
        drop_s         = bus.in_val & ~bus.rdreq_ff_addr;
    end

    // Alignment stage, registered bank writes, vector counter and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r         <= 1'b0;
            d1_real_r    <= '0;
            d1_imag_r    <= '0;
            cnt_r        <= '0;
            wr_en_r      <= '0;
            wr_addr_r    <= '0;
            wr_real_r    <= '0;
            wr_imag_r    <= '0;
            frame_done_r <= 1'b0;
            err_ovf_r    <= 1'b0;
            err_udf_r    <= 1'b0;
        end else begin
            v1_r      <= bus.in_val;
            d1_real_r <= bus.din_real;
            d1_imag_r <= bus.din_imag;
            wr_en_r   <= mask_s;
            for (int k = 0; k < N_LANES; k++) begin
                wr_addr_r[k] <= mask_s[k] ? lane_addr_s[k] : '0;
                wr_real_r[k] <= mask_s[k] ? d1_real_r[k]   : '0;
                wr_imag_r[k] <= mask_s[k] ? d1_imag_r[k]   : '0;
            end
            frame_done_r <= vec_ok_s & last_s;
            if (bus.sclr_ff_addr) begin
                cnt_r <= '0;
            end else if (vec_ok_s) begin
                cnt_r <= last_s ? '0 : cnt_r + W_CNT'(1);
            end
            err_ovf_r <= err_ovf_r | ovf_s;
            err_udf_r <= err_udf_r | udf_s | drop_s;
        end
    end

    assign bus.wr_en      = wr_en_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_real    = wr_real_r;
    assign bus.wr_imag    = wr_imag_r;
    assign bus.frame_done = frame_done_r;
    assign bus.err_ovf    = err_ovf_r;
    assign bus.err_udf    = err_udf_r;

endmodule

// File: tb/tb_rdx_wb_ctrl.sv
// Directed self-checking bench for rdx_wb_ctrl: addressing, FIFO corner cases,
// frame counting, synchronous clear and mid-burst reset.
module tb_rdx_wb_ctrl;
    import rdx_wb_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rdx_wb_ctrl_if bus ();

    rdx_wb_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_lanes(input int base);
        for (int k = 0; k < N_LANES; k++) begin
            bus.din_real[k] = sample_t'(base + k);
            bus.din_imag[k] = sample_t'(base + 40 + k);
        end
    endtask

    task automatic push(input int addr);
        bus.addr_wrreq = 1'b1;
        bus.addr_in    = addr_t'(addr);
        tick();
        bus.addr_wrreq = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.factor        = 3'd0;
        bus.stride        = '0;
        bus.frame_len     = '0;
        bus.addr_wrreq    = 1'b0;
        bus.addr_in       = '0;
        bus.sclr_ff_addr  = 1'b0;
        bus.rdreq_ff_addr = 1'b0;
        bus.in_val        = 1'b0;
        load_lanes(0);
        tick();
        tick();
        check("rst_wr_en",      64'(bus.wr_en), 64'(0));
        check("rst_ff_empty",   64'(bus.ff_empty), 64'(1));
        check("rst_ff_full",    64'(bus.ff_full), 64'(0));
        check("rst_err_ovf",    64'(bus.err_ovf), 64'(0));
        check("rst_err_udf",    64'(bus.err_udf), 64'(0));
        check("rst_frame_done", 64'(bus.frame_done), 64'(0));
        rst_n = 1'b1;

        // radix 3, stride 4: two vectors on bases 100 and 200
        bus.factor = RDX3;
        bus.stride = addr_t'(4);
        push(100);
        push(200);
        load_lanes(10);
        bus.in_val = 1'b1;
        bus.rdreq_ff_addr = 1'b1;
        tick();
        load_lanes(20);
        tick();
        bus.in_val = 1'b0;
        bus.rdreq_ff_addr = 1'b0;
        check("t1_v0_wr_en", 64'(bus.wr_en), 64'(5'b00111));
        for (int k = 0; k < 3; k++) check("t1_v0_addr", 64'(bus.wr_addr[k]), 64'(100 + 4 * k));
        check("t1_v0_real2",   64'(bus.wr_real[2]), 64'(12));
        check("t1_v0_imag0",   64'(bus.wr_imag[0]), 64'(50));
        check("t1_v0_real3_0", 64'(bus.wr_real[3]), 64'(0));
        check("t1_frame_done", 64'(bus.frame_done), 64'(0));
        tick();
        check("t1_v1_wr_en", 64'(bus.wr_en), 64'(5'b00111));
        for (int k = 0; k < 3; k++) check("t1_v1_addr", 64'(bus.wr_addr[k]), 64'(200 + 4 * k));
        check("t1_v1_real1", 64'(bus.wr_real[1]), 64'(21));
        tick();
        check("t1_idle_wr_en", 64'(bus.wr_en), 64'(0));
        check("t1_ff_empty",   64'(bus.ff_empty), 64'(1));

        // radix 5, stride 1023: addresses wrap modulo 1024
        bus.factor = RDX5;
        bus.stride = addr_t'(1023);
        push(5);
        load_lanes(30);
        bus.in_val = 1'b1;
        bus.rdreq_ff_addr = 1'b1;
        tick();
        bus.in_val = 1'b0;
        bus.rdreq_ff_addr = 1'b0;
        tick();
        check("t2_wr_en", 64'(bus.wr_en), 64'(5'b11111));
        for (int k = 0; k < 5; k++) check("t2_wrap_addr", 64'(bus.wr_addr[k]), 64'(5 - k));
        check("t2_real4", 64'(bus.wr_real[4]), 64'(34));

        // fill to depth, pop+push while full, then overflow
        bus.addr_wrreq = 1'b1;
        for (int i = 0; i < FF_DEPTH; i++) begin
            bus.addr_in = addr_t'(i);
            tick();
        end
        bus.addr_wrreq = 1'b0;
        check("t3_full",  64'(bus.ff_full), 64'(1));
        check("t3_empty", 64'(bus.ff_empty), 64'(0));
        bus.addr_wrreq = 1'b1;
        bus.rdreq_ff_addr = 1'b1;
        tick();
        bus.addr_wrreq = 1'b0;
        bus.rdreq_ff_addr = 1'b0;
        check("t3_poppush_full", 64'(bus.ff_full), 64'(1));
        check("t3_poppush_ovf",  64'(bus.err_ovf), 64'(0));
        push(77);
        check("t3_ovf",        64'(bus.err_ovf), 64'(1));
        check("t3_full_after", 64'(bus.ff_full), 64'(1));
        bus.rdreq_ff_addr = 1'b1;
        for (int i = 0; i < FF_DEPTH - 1; i++) tick();
        check("t3_not_empty_31", 64'(bus.ff_empty), 64'(0));
        tick();
        bus.rdreq_ff_addr = 1'b0;
        check("t3_empty_32",  64'(bus.ff_empty), 64'(1));
        check("t3_no_udf",    64'(bus.err_udf), 64'(0));
        check("t3_no_writes", 64'(bus.wr_en), 64'(0));

        // vector arrives with the FIFO empty
        bus.in_val = 1'b1;
        bus.rdreq_ff_addr = 1'b1;
        tick();
        bus.in_val = 1'b0;
        bus.rdreq_ff_addr = 1'b0;
        check("t4_udf", 64'(bus.err_udf), 64'(1));
        tick();
        check("t4_wr_en", 64'(bus.wr_en), 64'(0));

        // clear with a same-cycle push; also restarts the vector counter
        push(1);
        push(2);
        bus.sclr_ff_addr = 1'b1;
        push(999);
        bus.sclr_ff_addr = 1'b0;
        check("t6_sclr_empty", 64'(bus.ff_empty), 64'(1));
        check("t6_sclr_full",  64'(bus.ff_full), 64'(0));

        // frame_len 4, radix 2: frame_done on the 4th and 8th writes
        bus.factor = RDX2;
        bus.stride = addr_t'(1);
        bus.frame_len = 12'd4;
        for (int i = 0; i < 8; i++) push(10 * i);
        for (int n = 1; n <= 10; n++) begin
            bus.in_val = (n <= 8);
            bus.rdreq_ff_addr = (n <= 8);
            load_lanes(n);
            tick();
            if (n >= 2 && n <= 9) begin
                check("t5_wr_en",  64'(bus.wr_en), 64'(5'b00011));
                check("t5_addr0",  64'(bus.wr_addr[0]), 64'(10 * (n - 2)));
                check("t5_addr1",  64'(bus.wr_addr[1]), 64'(10 * (n - 2) + 1));
                check("t5_done",   64'(bus.frame_done), 64'((n - 1) % 4 == 0));
            end else if (n == 10) begin
                check("t5_tail_wr_en", 64'(bus.wr_en), 64'(0));
                check("t5_tail_done",  64'(bus.frame_done), 64'(0));
            end
        end
        bus.in_val = 1'b0;
        bus.rdreq_ff_addr = 1'b0;

        // reset asserted mid-burst
        for (int i = 0; i < 4; i++) push(300 + i);
        bus.in_val = 1'b1;
        bus.rdreq_ff_addr = 1'b1;
        load_lanes(60);
        tick();
        tick();
        check("t7_burst_wr_en", 64'(bus.wr_en), 64'(5'b00011));
        rst_n = 1'b0;
        tick();
        check("t7_rst_wr_en",   64'(bus.wr_en), 64'(0));
        check("t7_rst_addr0",   64'(bus.wr_addr[0]), 64'(0));
        check("t7_rst_real0",   64'(bus.wr_real[0]), 64'(0));
        check("t7_rst_empty",   64'(bus.ff_empty), 64'(1));
        check("t7_rst_ovf",     64'(bus.err_ovf), 64'(0));
        check("t7_rst_udf",     64'(bus.err_udf), 64'(0));
        check("t7_rst_done",    64'(bus.frame_done), 64'(0));
        bus.in_val = 1'b0;
        bus.rdreq_ff_addr = 1'b0;
        rst_n = 1'b1;
        tick();
        check("t7_post_wr_en", 64'(bus.wr_en), 64'(0));
        tick();
        check("t7_post2_wr_en", 64'(bus.wr_en), 64'(0));
        check("t7_post_empty",  64'(bus.ff_empty), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
